// File: rtl/countdown_timer.sv
// Countdown timer (hh:mm:ss, up to 11:59:59) with load/start/pause control.
// All state, including every output, updates on the falling edge of clk.
module countdown_timer (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic [3:0] i_hh,
  input  logic [5:0] i_mm,
  input  logic [5:0] i_ss,
  input  logic       start,
  input  logic       pause,
  input  logic       tick,
  output logic [3:0] hh,
  output logic [5:0] mm,
  output logic [5:0] ss,
  output logic       running,
  output logic       done,
  output logic       expired
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    PAUSED = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t     state_reg, state_next;
  logic [3:0] hh_reg, hh_next;
  logic [5:0] mm_reg, mm_next;
  logic [5:0] ss_reg, ss_next;
  logic       running_reg, done_reg, expired_reg, expired_next;

  logic [3:0] load_hh;
  logic [5:0] load_mm, load_ss;
  logic [3:0] dec_hh;
  logic [5:0] dec_mm, dec_ss;
  logic       count_zero, count_one;

  // Out-of-range presets saturate to the largest legal value.
  assign load_hh = (i_hh > 4'd11)  ? 4'd11  : i_hh;
  assign load_mm = (i_mm > 6'd59)  ? 6'd59  : i_mm;
  assign load_ss = (i_ss > 6'd59)  ? 6'd59  : i_ss;

  assign count_zero = (hh_reg == 4'd0) && (mm_reg == 6'd0) && (ss_reg == 6'd0);
  assign count_one  = (hh_reg == 4'd0) && (mm_reg == 6'd0) && (ss_reg == 6'd1);

  // One-second decrement with borrow; 00:00:00 holds rather than wrapping.
  always_comb begin
    dec_hh = hh_reg;
    dec_mm = mm_reg;
    dec_ss = ss_reg;
    if (ss_reg != 6'd0) begin
      dec_ss = ss_reg - 6'd1;
    end else if (mm_reg != 6'd0) begin
      dec_ss = 6'd59;
      dec_mm = mm_reg - 6'd1;
    end else if (hh_reg != 4'd0) begin
      dec_ss = 6'd59;
      dec_mm = 6'd59;
      dec_hh = hh_reg - 4'd1;
    end
  end

  always_comb begin
    state_next   = state_reg;
    hh_next      = hh_reg;
    mm_next      = mm_reg;
    ss_next      = ss_reg;
    expired_next = 1'b0;
    if (load) begin
      state_next = IDLE;
      hh_next    = load_hh;
      mm_next    = load_mm;
      ss_next    = load_ss;
    end else begin
      case (state_reg)
        IDLE: begin
          if (start && !count_zero) state_next = RUN;
        end
        RUN: begin
          // A tick coinciding with pause is dropped.
          if (pause) begin
            state_next = PAUSED;
          end else if (tick) begin
            hh_next = dec_hh;
            mm_next = dec_mm;
            ss_next = dec_ss;
            if (count_one) begin
              state_next   = DONE;
              expired_next = 1'b1;
            end
          end
        end
        PAUSED: begin
          if (start && !pause) state_next = RUN;
        end
        DONE: begin
          state_next = DONE;
        end
        default: begin
          state_next = IDLE;
        end
      endcase
    end
  end

  always_ff @(negedge clk or negedge reset) begin
    if (!reset) begin
      state_reg   <= IDLE;
      hh_reg      <= 4'd0;
      mm_reg      <= 6'd0;
      ss_reg      <= 6'd0;
      running_reg <= 1'b0;
      done_reg    <= 1'b0;
      expired_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      hh_reg      <= hh_next;
      mm_reg      <= mm_next;
      ss_reg      <= ss_next;
      running_reg <= (state_next == RUN);
      done_reg    <= (state_next == DONE);
      expired_reg <= expired_next;
    end
  end

  assign hh      = hh_reg;
  assign mm      = mm_reg;
  assign ss      = ss_reg;
  assign running = running_reg;
  assign done    = done_reg;
  assign expired = expired_reg;

endmodule
